// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: machine word and the fetch queue entry.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
    logic      pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Register array for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are never cleared.
module fq_storage
  import rv32i_types::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {pc, instr, pred_taken}; a redirect (flush) drops
// every buffered wrong-path entry in one cycle.
module fetch_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_instr,
  input  logic             enq_pred_taken,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_instr,
  output logic             deq_pred_taken,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             enq_fire, deq_fire;
  fetch_entry_t     enq_entry, head_entry;

  // valid/ready: a beat transfers on a cycle where both are high at the
  // posedge. enq_ready and deq_valid are functions of count_q only, so a full
  // queue never accepts even while it is being drained.
  assign deq_valid = (count_q != '0);
  assign enq_ready = (count_q != FULL_COUNT);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_ONE;
      if (deq_fire) head_d = head_q + PTR_ONE;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign enq_entry = '{pc: enq_pc, instr: enq_instr, pred_taken: enq_pred_taken};

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq_fire & ~flush & ~rst),
    .waddr (tail_q),
    .wdata (enq_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  // Storage is never cleared, so mask the head while empty to keep stale
  // entries off the decode inputs.
  assign deq_pc         = deq_valid ? head_entry.pc         : '0;
  assign deq_instr      = deq_valid ? head_entry.instr      : '0;
  assign deq_pred_taken = deq_valid ? head_entry.pred_taken : 1'b0;
  assign count          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based model.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int W     = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_instr = '0;
  logic        enq_pred_taken = 1'b0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_pred_taken;
  logic [3:0]  count;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic src_took;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_pc         (enq_pc),
    .enq_instr      (enq_instr),
    .enq_pred_taken (enq_pred_taken),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .deq_pred_taken (deq_pred_taken),
    .count          (count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_state();
    logic [W-1:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("deq_valid", W'(deq_valid), W'(exp_q.size() != 0));
    check("enq_ready", W'(enq_ready), W'(exp_q.size() != DEPTH));
    check("count", W'(count), W'(exp_q.size()));
    check("deq_entry", {deq_pc, deq_instr, deq_pred_taken}, exp_head);
    check("count_le_depth", W'(count <= 4'(DEPTH)), W'(1));
  endtask

  // One clock: check, drive, advance the model, cross the posedge.
  task automatic step(input logic r, input logic f, input logic ev,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic pt, input logic dr);
    logic acc_enq, acc_deq;
    check_state();
    rst = r; flush = f; enq_valid = ev; enq_pc = pc; enq_instr = instr;
    enq_pred_taken = pt; deq_ready = dr;
    src_took = ev & enq_ready;
    acc_enq = ev && (exp_q.size() < DEPTH);
    acc_deq = dr && (exp_q.size() > 0);
    if (r || f) begin
      exp_q.delete();
    end else begin
      if (acc_deq) void'(exp_q.pop_front());
      if (acc_enq) exp_q.push_back({pc, instr, pt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, dr);
  endtask

  task automatic push(input logic [31:0] pc, input logic dr);
    step(1'b0, 1'b0, 1'b1, pc, $urandom, 1'($urandom_range(0, 1)), dr);
  endtask

  initial begin
    int i;
    // reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_deq_valid", W'(deq_valid), W'(0));
    check("reset_enq_ready", W'(enq_ready), W'(1));
    check("reset_count", W'(count), W'(0));
    check("reset_deq_instr", W'(deq_instr), W'(0));
    idle(1'b1);

    // single pass
    step(1'b0, 1'b0, 1'b1, 32'h6000_0000, 32'h0050_0093, 1'b0, 1'b1);
    check("single_valid", W'(deq_valid), W'(1));
    check("single_pc", W'(deq_pc), W'(32'h6000_0000));
    check("single_instr", W'(deq_instr), W'(32'h0050_0093));
    check("single_count1", W'(count), W'(1));
    idle(1'b1);
    check("single_count0", W'(count), W'(0));

    // fill with backpressure; the source holds an offer until accepted
    i = 0;
    for (int c = 0; c < 12; c++) begin
      push(32'h100 + 32'(4 * i), 1'b0);
      if (src_took) i++;
    end
    check("fill_count", W'(count), W'(8));
    check("fill_enq_ready", W'(enq_ready), W'(0));
    check("fill_accepted", W'(i), W'(8));
    check("fill_head_pc", W'(deq_pc), W'(32'h100));
    for (int c = 0; c < 40 && (i < 10 || exp_q.size() != 0); c++) begin
      if (i < 10) begin
        push(32'h100 + 32'(4 * i), 1'b1);
        if (src_took) i++;
      end else begin
        idle(1'b1);
      end
    end
    check("drain_all_sent", W'(i), W'(10));
    check("drain_empty", W'(count), W'(0));

    // simultaneous enq/deq at count 3, across pointer wrap
    repeat (3) push($urandom, 1'b0);
    check("sim_count_pre", W'(count), W'(3));
    repeat (20) push($urandom, 1'b1);
    check("sim_count_post", W'(count), W'(3));
    repeat (20) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // flush at count 5 with a concurrent enqueue
    while (exp_q.size() > 0) idle(1'b1);
    repeat (5) push($urandom, 1'b0);
    check("flush_count_pre", W'(count), W'(5));
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 1'b1, 1'b1);
    check("flush_count", W'(count), W'(0));
    check("flush_deq_valid", W'(deq_valid), W'(0));
    push(32'h200, 1'b0);
    check("flush_next_pc", W'(deq_pc), W'(32'h200));

    // reset mid-stream together with flush and enqueue
    repeat (3) push($urandom, 1'b0);
    check("rst_count_pre", W'(count), W'(4));
    step(1'b1, 1'b1, 1'b1, 32'hBAD0_0000, 32'h2, 1'b1, 1'b0);
    check("rst_count", W'(count), W'(0));
    check("rst_deq_pc", W'(deq_pc), W'(0));
    check("rst_deq_valid", W'(deq_valid), W'(0));

    // random soak
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 127) == 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- FIFO between the fetch unit (I-cache response plus PC/prediction) and the decode unit.
- Holds {pc, instr, pred_taken} entries. Decoupling lets an I-cache hit land while decode is stalled.
- On a backend redirect it drops all buffered wrong-path instructions in one cycle.
- Head entry drives the decode stage's instr/pc inputs.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..32.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  redirect; discard all contents this cycle.
- enq_valid  input  1  fetch offers an entry.
- enq_ready  output  1  queue accepts; equals !full.
- enq_pc  input  32  PC of offered instruction.
- enq_instr  input  32  raw instruction word.
- enq_pred_taken  input  1  branch predictor verdict for this PC.
- deq_valid  output  1  head entry valid for decode.
- deq_ready  input  1  decode consumes head this cycle.
- deq_pc  output  32  head PC.
- deq_instr  output  32  head instruction.
- deq_pred_taken  output  1  head prediction bit.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset:
  - rst is synchronous, active-high, and sampled on the posedge of clk.
  - It clears head pointer, tail pointer and count to 0.
  - After reset: deq_valid=0, enq_ready=1, count=0. deq_pc, deq_instr and deq_pred_taken read 0.
  - rst has priority over flush and over all handshakes.
- Handshake:
  - Enqueue fires when enq_valid & enq_ready.
  - Dequeue fires when deq_valid & deq_ready.
  - Both may fire in the same cycle.
- Latency:
  - An entry enqueued in cycle N is visible at deq_* in cycle N+1 at the earliest.
  - There is no combinational path from enq_* to deq_*.
- Outputs:
  - deq_* come from the storage entry at the head pointer.
  - They are held stable while deq_valid=1 and deq_ready=0.
  - deq_valid = (count != 0). enq_ready = (count != DEPTH).
  - Neither depends combinationally on enq_valid or deq_ready.
- Full: enq_ready=0. A simultaneous dequeue does not open a slot in the same cycle (no pass-through when full).
- Empty:
  - deq_valid=0, and deq_ready is ignored.
  - An enqueue into an empty queue gives deq_valid=1 next cycle.
- Count update:
  - +1 on enqueue only; -1 on dequeue only; unchanged when both fire or neither fires.
- Wrap-around:
  - Pointers are PTR_W bits and wrap modulo DEPTH naturally.
  - Full/empty are decided by count, never by pointer equality.
- Flush:
  - Next cycle: head=tail=0, count=0, deq_valid=0.
  - Any enqueue or dequeue presented in the flush cycle is discarded.
  - enq_ready in the flush cycle reflects pre-flush state; the beat is dropped regardless.
- Storage: entries are not cleared on flush or reset; only the pointers and count are.
- Assertions (bench):
  - count <= DEPTH at all times.
  - No enqueue when full and no dequeue when empty (guaranteed by ready/valid).

Decomposition:
- Package rv32i_types gains fetch_entry_t, a packed struct {rv32i_word pc; rv32i_word instr; logic pred_taken}.
- Storage and both ports use fetch_entry_t.
- One sub-module: fq_storage.
  - DEPTH x fetch_entry_t register array.
  - Write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
- fetch_queue owns the pointers, count and flush/reset control.

Test Plan:
- Reset then idle: assert rst 2 cycles -> deq_valid=0, enq_ready=1, count=0. deq_instr=0 as required by Behaviour.
- Single pass: enqueue pc=0x60000000, instr=0x00500093 (addi x1,x0,5), with deq_ready=1.
  - Required: deq_valid=1 next cycle with the same pc/instr.
  - Required: count 1 then 0 after consumption.
- Fill and backpressure, DEPTH=8, deq_ready=0:
  - Enqueue 10 entries with pc=0x100+4i -> enq_ready drops after the 8th, count=8, entries 9-10 are held by the source.
  - Then deq_ready=1 -> 8 outputs in order 0x100..0x11C, then 9 and 10.
- Simultaneous enq/deq at count=3 -> count stays 3; FIFO order is preserved across pointer wrap over 20 mixed cycles.
- Flush with count=5 and concurrent enq_valid=1 -> next cycle count=0, deq_valid=0.
  - The next enqueue (pc=0x200) is the first dequeued.
- Reset mid-stream: rst asserted at count=4 together with flush and enq -> count=0 next cycle; no stale entry ever appears at deq_*.
